// File: rtl/param_register_file_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// param_register_file_pkg : shared widths and user-FSM state encoding (rev 1.0)
// -----------------------------------------------------------------------------
package param_register_file_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    RESP = 2'd2
  } user_state_t;

endpackage
`default_nettype wire

// File: rtl/param_register_file_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// param_register_file_if : host and user-side signals of the register file (rev 1.0)
// -----------------------------------------------------------------------------
interface param_register_file_if;
  import param_register_file_pkg::*;

  // host side
  logic                  hostWriteEn;
  logic [ADDR_WIDTH-1:0] hostAddress;
  logic [REG_WIDTH-1:0]  hostWriteData;
  logic                  hostReadEn;
  logic [REG_WIDTH-1:0]  hostReadData;
  logic                  hostReadDataValid;
  logic                  hostRunSet;
  logic                  hostRunValue;

  // user side
  logic                  userRunValue;
  logic                  userRunClear;
  logic                  register32CmdReq;
  logic                  register32CmdAck;
  logic [ADDR_WIDTH-1:0] register32Address;
  logic                  register32WriteEn;
  logic [REG_WIDTH-1:0]  register32WriteData;
  logic                  register32ReadDataValid;
  logic [REG_WIDTH-1:0]  register32ReadData;

  modport master (
    output hostWriteEn, hostAddress, hostWriteData, hostReadEn, hostRunSet,
    output userRunClear, register32CmdReq, register32Address,
    output register32WriteEn, register32WriteData,
    input  hostReadData, hostReadDataValid, hostRunValue, userRunValue,
    input  register32CmdAck, register32ReadDataValid, register32ReadData
  );

  modport slave (
    input  hostWriteEn, hostAddress, hostWriteData, hostReadEn, hostRunSet,
    input  userRunClear, register32CmdReq, register32Address,
    input  register32WriteEn, register32WriteData,
    output hostReadData, hostReadDataValid, hostRunValue, userRunValue,
    output register32CmdAck, register32ReadDataValid, register32ReadData
  );

endinterface
`default_nettype wire

// File: rtl/param_register_file_reg_array.sv
`default_nettype none
// -----------------------------------------------------------------------------
// param_reg_array : NUM_REGS x 32-bit flop array with host/user ports (rev 1.0)
// -----------------------------------------------------------------------------
module param_reg_array
  import param_register_file_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  host_we,
  input  wire logic [ADDR_WIDTH-1:0] host_addr,
  input  wire logic [REG_WIDTH-1:0]  host_wdata,
  input  wire logic                  host_re,
  output logic                       host_rvalid,
  output logic [REG_WIDTH-1:0]       host_rdata,
  input  wire logic                  user_we,
  input  wire logic [ADDR_WIDTH-1:0] user_addr,
  input  wire logic [REG_WIDTH-1:0]  user_wdata,
  output logic [REG_WIDTH-1:0]       user_rdata
);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [REG_WIDTH-1:0] host_sel;

  // Host is checked first so it wins a same-address collision with the user.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (host_we && (host_addr == ADDR_WIDTH'(i))) begin
          regs[i] <= host_wdata;
        end else if (user_we && (user_addr == ADDR_WIDTH'(i))) begin
          regs[i] <= user_wdata;
        end
      end
    end
  end

  // Addresses with no matching register fall through to the zero default.
  always_comb begin
    user_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (user_addr == ADDR_WIDTH'(i)) begin
        user_rdata = regs[i];
      end
    end
  end

  always_comb begin
    host_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (host_addr == ADDR_WIDTH'(i)) begin
        host_sel = regs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_re;
      host_rdata  <= host_re ? host_sel : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_register_file.sv
`default_nettype none
// -----------------------------------------------------------------------------
// param_register_file : parameter register file, host port + user req/ack port (rev 1.0)
// -----------------------------------------------------------------------------
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  wire logic            clk,
  input  wire logic            reset,
  param_register_file_if.slave bus
);

  user_state_t           state;
  user_state_t           state_next;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_we;
  logic [REG_WIDTH-1:0]  cap_wdata;
  logic                  cmd_ack;
  logic                  user_rvalid;
  logic                  user_we;
  logic [REG_WIDTH-1:0]  user_rdata;
  logic                  run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The command is latched at the ACK edge, so the requester may drop req afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
    end else if (state == ACK) begin
      cap_addr  <= bus.register32Address;
      cap_we    <= bus.register32WriteEn;
      cap_wdata <= bus.register32WriteData;
    end
  end

  always_comb begin
    state_next  = state;
    cmd_ack     = 1'b0;
    user_rvalid = 1'b0;
    user_we     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.register32CmdReq) begin
          state_next = ACK;
        end
      end
      ACK: begin
        cmd_ack    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        user_we     = cap_we;
        user_rvalid = ~cap_we;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
    end else if (bus.hostRunSet) begin
      run <= 1'b1;
    end else if (bus.userRunClear) begin
      run <= 1'b0;
    end
  end

  param_reg_array #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_array (
    .clk         (clk),
    .reset       (reset),
    .host_we     (bus.hostWriteEn),
    .host_addr   (bus.hostAddress),
    .host_wdata  (bus.hostWriteData),
    .host_re     (bus.hostReadEn),
    .host_rvalid (bus.hostReadDataValid),
    .host_rdata  (bus.hostReadData),
    .user_we     (user_we),
    .user_addr   (cap_addr),
    .user_wdata  (cap_wdata),
    .user_rdata  (user_rdata)
  );

  // The user read samples the array combinationally in RESP, i.e. before any same-edge write.
  assign bus.register32CmdAck        = cmd_ack;
  assign bus.register32ReadDataValid = user_rvalid;
  assign bus.register32ReadData      = user_rvalid ? user_rdata : '0;
  assign bus.hostRunValue            = run;
  assign bus.userRunValue            = run;

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// tb_param_register_file : directed stimulus, expected read returns queued and
// checked by monitors on the user and host read-return outputs.
module tb_param_register_file;
  import param_register_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_user_q [$];
  logic [31:0] exp_host_q [$];
  logic [31:0] model [256];

  param_register_file_if bus ();

  param_register_file #(
    .NUM_REGS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop an expectation on every read return, require zero data otherwise.
  always @(negedge clk) begin
    if (bus.register32ReadDataValid === 1'b1) begin
      if (exp_user_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL user_unexpected_return: got data 0x%08h required no return",
                 bus.register32ReadData);
      end else begin
        check("user_read_data", bus.register32ReadData, exp_user_q.pop_front());
      end
    end else begin
      check("user_read_data_idle", bus.register32ReadData, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (bus.hostReadDataValid === 1'b1) begin
      if (exp_host_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_unexpected_return: got data 0x%08h required no return",
                 bus.hostReadData);
      end else begin
        check("host_read_data", bus.hostReadData, exp_host_q.pop_front());
      end
    end else begin
      check("host_read_data_idle", bus.hostReadData, 32'd0);
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    bus.hostWriteEn   = 1'b1;
    bus.hostAddress   = a;
    bus.hostWriteData = d;
    tick();
    bus.hostWriteEn   = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a);
    bus.hostReadEn  = 1'b1;
    bus.hostAddress = a;
    exp_host_q.push_back(model[a]);
    tick();
    bus.hostReadEn  = 1'b0;
  endtask

  // One user transaction; optionally a host write is driven in the RESP cycle.
  task automatic user_txn(input logic [7:0] a, input logic we, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic hw,
                          input logic [7:0] ha, input logic [31:0] hd);
    bus.register32CmdReq    = 1'b1;
    bus.register32Address   = a;
    bus.register32WriteEn   = we;
    bus.register32WriteData = wd;
    if (!we) exp_user_q.push_back(exp_rd);
    tick();
    check("user_ack", 32'(bus.register32CmdAck), 32'd1);
    bus.register32CmdReq = 1'b0;
    tick();
    check("user_ack_one_cycle", 32'(bus.register32CmdAck), 32'd0);
    if (hw) begin
      bus.hostWriteEn   = 1'b1;
      bus.hostAddress   = ha;
      bus.hostWriteData = hd;
    end
    tick();
    bus.hostWriteEn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.hostWriteEn = 1'b0; bus.hostAddress = '0; bus.hostWriteData = '0;
    bus.hostReadEn = 1'b0; bus.hostRunSet = 1'b0; bus.userRunClear = 1'b0;
    bus.register32CmdReq = 1'b0; bus.register32Address = '0;
    bus.register32WriteEn = 1'b0; bus.register32WriteData = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    tick();
    tick();
    check("rst_ack",        32'(bus.register32CmdAck),        32'd0);
    check("rst_user_valid", 32'(bus.register32ReadDataValid), 32'd0);
    check("rst_user_data",  bus.register32ReadData,           32'd0);
    check("rst_host_valid", 32'(bus.hostReadDataValid),       32'd0);
    check("rst_host_data",  bus.hostReadData,                 32'd0);
    check("rst_run",        32'(bus.hostRunValue),            32'd0);
    reset = 1'b0;
    tick();

    // Held request: acks at T+1 and T+4, data 8 at T+2 and 3 at T+5.
    host_write(8'd0, 32'd8); model[0] = 32'd8;
    host_write(8'd1, 32'd3); model[1] = 32'd3;
    bus.hostRunSet = 1'b1;
    tick();
    bus.hostRunSet = 1'b0;
    check("run_set_host", 32'(bus.hostRunValue), 32'd1);
    check("run_set_user", 32'(bus.userRunValue), 32'd1);
    bus.register32CmdReq  = 1'b1;
    bus.register32Address = 8'd0;
    bus.register32WriteEn = 1'b0;
    exp_user_q.push_back(32'd8);
    check("held_ack_T0", 32'(bus.register32CmdAck), 32'd0);
    tick();
    check("held_ack_T1", 32'(bus.register32CmdAck), 32'd1);
    tick();
    check("held_ack_T2",   32'(bus.register32CmdAck),        32'd0);
    check("held_valid_T2", 32'(bus.register32ReadDataValid), 32'd1);
    bus.register32Address = 8'd1;
    exp_user_q.push_back(32'd3);
    tick();
    check("held_ack_T3",   32'(bus.register32CmdAck),        32'd0);
    check("held_valid_T3", 32'(bus.register32ReadDataValid), 32'd0);
    tick();
    check("held_ack_T4", 32'(bus.register32CmdAck), 32'd1);
    bus.register32CmdReq = 1'b0;
    tick();
    check("held_valid_T5", 32'(bus.register32ReadDataValid), 32'd1);
    tick();
    for (int a = 0; a < 3; a++) host_read(8'(a));

    // Collision: host wins same address; different addresses both commit.
    user_txn(8'd2, 1'b1, 32'hDEADBEEF, 32'd0, 1'b1, 8'd2, 32'h12345678);
    model[2] = 32'h12345678;
    user_txn(8'd3, 1'b1, 32'hA5A5A5A5, 32'd0, 1'b1, 8'd4, 32'h11112222);
    model[3] = 32'hA5A5A5A5;
    model[4] = 32'h11112222;
    for (int a = 2; a < 5; a++) host_read(8'(a));
    // Read-before-write against a same-cycle host write.
    user_txn(8'd4, 1'b0, 32'd0, 32'h11112222, 1'b1, 8'd4, 32'h33334444);
    model[4] = 32'h33334444;
    host_read(8'd4);
    user_txn(8'd3, 1'b0, 32'd0, 32'hA5A5A5A5, 1'b0, 8'd0, 32'd0);

    // Run register: set wins over clear, then clear alone.
    bus.hostRunSet = 1'b1; bus.userRunClear = 1'b1;
    tick();
    bus.hostRunSet = 1'b0; bus.userRunClear = 1'b0;
    check("run_set_wins_host", 32'(bus.hostRunValue), 32'd1);
    check("run_set_wins_user", 32'(bus.userRunValue), 32'd1);
    bus.userRunClear = 1'b1;
    check("run_clear_registered", 32'(bus.userRunValue), 32'd1);
    tick();
    bus.userRunClear = 1'b0;
    check("run_cleared_host", 32'(bus.hostRunValue), 32'd0);
    check("run_cleared_user", 32'(bus.userRunValue), 32'd0);

    // Out-of-range address 200: reads zero, write dropped (200 mod 16 = 8).
    user_txn(8'd200, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    user_txn(8'd200, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 8'd0, 32'd0);
    for (int a = 0; a < 16; a++) host_read(8'(a));
    host_read(8'd200);

    // Reset during ACK of a user write aborts it.
    bus.register32CmdReq    = 1'b1;
    bus.register32Address   = 8'd5;
    bus.register32WriteEn   = 1'b1;
    bus.register32WriteData = 32'd7;
    tick();
    check("abort_ack", 32'(bus.register32CmdAck), 32'd1);
    reset = 1'b1;
    bus.register32CmdReq = 1'b0;
    tick();
    check("abort_ack_dropped", 32'(bus.register32CmdAck),        32'd0);
    check("abort_no_valid",    32'(bus.register32ReadDataValid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    tick();
    check("abort_idle_ack", 32'(bus.register32CmdAck), 32'd0);
    host_read(8'd5);
    host_read(8'd0);

    // Host reads every cycle while user traffic runs.
    host_write(8'd0, 32'h00000010); model[0] = 32'h00000010;
    host_write(8'd7, 32'h00000077); model[7] = 32'h00000077;
    fork
      begin
        user_txn(8'd7, 1'b0, 32'd0, 32'h00000077, 1'b0, 8'd0, 32'd0);
        user_txn(8'd1, 1'b1, 32'h00000021, 32'd0, 1'b0, 8'd0, 32'd0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          bus.hostReadEn  = 1'b1;
          bus.hostAddress = (i % 2 == 1) ? 8'd7 : 8'd0;
          exp_host_q.push_back(model[bus.hostAddress]);
          tick();
          check("host_valid_streaming", 32'(bus.hostReadDataValid), 32'd1);
        end
        bus.hostReadEn = 1'b0;
      end
    join
    model[1] = 32'h00000021;
    host_read(8'd1);
    user_txn(8'd1, 1'b0, 32'd0, 32'h00000021, 1'b0, 8'd0, 32'd0);

    tick();
    tick();
    check("user_queue_drained", 32'(exp_user_q.size()), 32'd0);
    check("host_queue_drained", 32'(exp_host_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
